// File: rtl/fuzzy_mmio_pkg.sv
// Shared definitions for the fuzzy-core MMIO host: register map, CTRL/STATUS
// bit positions and the host sequencer state encoding.
package fuzzy_mmio_pkg;

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h01;
    localparam logic [7:0] ADDR_T      = 8'h02;
    localparam logic [7:0] ADDR_DT     = 8'h03;
    localparam logic [7:0] ADDR_G      = 8'h04;

    localparam int CTRL_START    = 0;
    localparam int CTRL_REG_MODE = 1;
    localparam int CTRL_DT_MODE  = 2;
    localparam int CTRL_INIT     = 3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_VALID = 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_MODE  = 4'd1,
        ST_WR_T     = 4'd2,
        ST_WR_DT    = 4'd3,
        ST_WR_START = 4'd4,
        ST_GAP      = 4'd5,
        ST_RD_STAT  = 4'd6,
        ST_RD_G     = 4'd7,
        ST_RD_DT    = 4'd8,
        ST_DONE     = 4'd9
    } host_state_e;

    function automatic logic [7:0] ctrl_word(input logic init, input logic dt_mode,
                                             input logic reg_mode, input logic start);
        logic [7:0] w;
        w                = 8'h00;
        w[CTRL_START]    = start;
        w[CTRL_REG_MODE] = reg_mode;
        w[CTRL_DT_MODE]  = dt_mode;
        w[CTRL_INIT]     = init;
        return w;
    endfunction

endpackage

// File: rtl/fuzzy_mmio_host.sv
// MMIO bus initiator that runs one complete fuzzy-core inference job per request:
// mode setup, operand load, START, STATUS polling, then G/dT readback.
module fuzzy_mmio_host
    import fuzzy_mmio_pkg::*;
#(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_T,
    input  logic [7:0] req_dT,
    input  logic       req_reg_mode,
    input  logic       req_dt_mode,
    input  logic       req_init,
    output logic       res_valid,
    output logic [7:0] res_G,
    output logic [7:0] res_dT,
    output logic       res_timeout,
    output logic       bus_cs,
    output logic       bus_rd,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [7:0]       POLL_LAST = 8'(MAX_POLLS - 1);

    host_state_e      state_q, state_d;
    logic [7:0]       t_q, t_d, dt_q, dt_d, g_q, g_d, poll_cnt_q, poll_cnt_d;
    logic             reg_mode_q, reg_mode_d, dt_mode_q, dt_mode_d, init_q, init_d;
    logic             timeout_q, timeout_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             bus_cs_q, bus_cs_d, bus_rd_q, bus_rd_d, bus_wr_q, bus_wr_d;
    logic [7:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic             res_valid_q, res_valid_d, res_timeout_q, res_timeout_d;
    logic [7:0]       res_g_q, res_g_d, res_dt_q, res_dt_d;
    logic             req_ready_q, req_ready_d, busy_q, busy_d;
    logic             accept_s, stat_ready_s;

    assign accept_s     = (state_q == ST_IDLE) && req_valid;
    assign stat_ready_s = bus_rdata[STAT_VALID] && !bus_rdata[STAT_BUSY];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STATUS is judged on the rdata present at the end of RD_STAT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req_valid) state_d = ST_WR_MODE; else state_d = ST_IDLE;
            ST_WR_MODE:  state_d = ST_WR_T;
            ST_WR_T:     if (dt_mode_q) state_d = ST_WR_START; else state_d = ST_WR_DT;
            ST_WR_DT:    state_d = ST_WR_START;
            ST_WR_START: state_d = ST_GAP;
            ST_GAP:      if (gap_cnt_q == GAP_LAST) state_d = ST_RD_STAT; else state_d = ST_GAP;
            ST_RD_STAT: begin
                if (stat_ready_s) begin
                    state_d = ST_RD_G;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_RD_G:     state_d = ST_RD_DT;
            ST_RD_DT:    state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Job capture, gap/poll counters and G capture.
    always_comb begin
        t_d        = t_q;
        dt_d       = dt_q;
        reg_mode_d = reg_mode_q;
        dt_mode_d  = dt_mode_q;
        init_d     = init_q;
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
        g_d        = g_q;
        gap_cnt_d  = {GAP_W{1'b0}};
        if (accept_s) begin
            t_d        = req_T;
            dt_d       = req_dT;
            reg_mode_d = req_reg_mode;
            dt_mode_d  = req_dt_mode;
            init_d     = req_init;
            poll_cnt_d = 8'h00;
            timeout_d  = 1'b0;
            g_d        = 8'h00;
        end else begin
            t_d = t_q;
        end
        if (state_q == ST_GAP && gap_cnt_q != GAP_LAST) begin
            gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end else begin
            gap_cnt_d = {GAP_W{1'b0}};
        end
        if (state_q == ST_RD_STAT && !stat_ready_s) begin
            poll_cnt_d = poll_cnt_q + 8'd1;
            timeout_d  = (poll_cnt_q == POLL_LAST);
        end else begin
            poll_cnt_d = poll_cnt_d;
        end
        if (state_q == ST_RD_G) begin
            g_d = bus_rdata;
        end else begin
            g_d = g_d;
        end
    end

    // Output decode from the next state so every bus/result output is a flop.
    always_comb begin
        bus_cs_d      = 1'b0;
        bus_rd_d      = 1'b0;
        bus_wr_d      = 1'b0;
        bus_addr_d    = 8'h00;
        bus_wdata_d   = 8'h00;
        res_valid_d   = 1'b0;
        res_timeout_d = res_timeout_q;
        res_g_d       = res_g_q;
        res_dt_d      = res_dt_q;
        case (state_d)
            ST_WR_MODE: begin
                {bus_cs_d, bus_wr_d} = 2'b11;
                bus_addr_d  = ADDR_CTRL;
                bus_wdata_d = ctrl_word(init_d, dt_mode_d, reg_mode_d, 1'b0);
            end
            ST_WR_T: begin
                {bus_cs_d, bus_wr_d} = 2'b11;
                bus_addr_d  = ADDR_T;
                bus_wdata_d = t_d;
            end
            ST_WR_DT: begin
                {bus_cs_d, bus_wr_d} = 2'b11;
                bus_addr_d  = ADDR_DT;
                bus_wdata_d = dt_d;
            end
            ST_WR_START: begin
                {bus_cs_d, bus_wr_d} = 2'b11;
                bus_addr_d  = ADDR_CTRL;
                bus_wdata_d = ctrl_word(1'b0, dt_mode_d, reg_mode_d, 1'b1);
            end
            ST_RD_STAT: begin
                {bus_cs_d, bus_rd_d} = 2'b11;
                bus_addr_d = ADDR_STATUS;
            end
            ST_RD_G: begin
                {bus_cs_d, bus_rd_d} = 2'b11;
                bus_addr_d = ADDR_G;
            end
            ST_RD_DT: begin
                {bus_cs_d, bus_rd_d} = 2'b11;
                bus_addr_d = ADDR_DT;
            end
            ST_DONE: begin
                res_valid_d   = 1'b1;
                res_timeout_d = timeout_d;
                res_g_d       = timeout_d ? 8'h00 : g_d;
                res_dt_d      = timeout_d ? 8'h00 : bus_rdata;
            end
            default: begin
                bus_cs_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q           <= 8'h00;
            dt_q          <= 8'h00;
            reg_mode_q    <= 1'b0;
            dt_mode_q     <= 1'b0;
            init_q        <= 1'b0;
            poll_cnt_q    <= 8'h00;
            timeout_q     <= 1'b0;
            g_q           <= 8'h00;
            gap_cnt_q     <= {GAP_W{1'b0}};
            bus_cs_q      <= 1'b0;
            bus_rd_q      <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_addr_q    <= 8'h00;
            bus_wdata_q   <= 8'h00;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_g_q       <= 8'h00;
            res_dt_q      <= 8'h00;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            t_q           <= t_d;
            dt_q          <= dt_d;
            reg_mode_q    <= reg_mode_d;
            dt_mode_q     <= dt_mode_d;
            init_q        <= init_d;
            poll_cnt_q    <= poll_cnt_d;
            timeout_q     <= timeout_d;
            g_q           <= g_d;
            gap_cnt_q     <= gap_cnt_d;
            bus_cs_q      <= bus_cs_d;
            bus_rd_q      <= bus_rd_d;
            bus_wr_q      <= bus_wr_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            res_valid_q   <= res_valid_d;
            res_timeout_q <= res_timeout_d;
            res_g_q       <= res_g_d;
            res_dt_q      <= res_dt_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_G       = res_g_q;
    assign res_dT      = res_dt_q;
    assign res_timeout = res_timeout_q;
    assign bus_cs      = bus_cs_q;
    assign bus_rd      = bus_rd_q;
    assign bus_wr      = bus_wr_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: doc/fuzzy_mmio_host.md
Name: fuzzy_mmio_host

Overview:
- Bus initiator for the fuzzy-core MMIO register slave. Drives the cs/rd/wr/addr/wdata/rdata bus through a complete inference transaction:
  - mode setup;
  - T and dT load;
  - START pulse;
  - STATUS polling, with no IRQ;
  - G and dT readback.
- Accepts one job at a time over a valid/ready request port and returns one result pulse.
- Sits between a test or host controller and the fuzzy core's register interface.

Parameters:
- POLL_GAP, 4: idle bus cycles before each STATUS read, including the first one after START; minimum 1.
- MAX_POLLS, 255: STATUS reads allowed before timeout; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  job request
- req_ready  out  1  high only in IDLE
- req_T  in  8  temperature value written to 0x02
- req_dT  in  8  external dT, written to 0x03 only when req_dt_mode=0
- req_reg_mode  in  1  CTRL[1] value
- req_dt_mode  in  1  CTRL[2] value
- req_init  in  1  set CTRL[3] (INIT) in the mode write
- res_valid  out  1  one-cycle result strobe
- res_G  out  8  value read from 0x04
- res_dT  out  8  value read from 0x03
- res_timeout  out  1  qualifies res_valid; job aborted on poll limit
- bus_cs  out  1  chip select
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_addr  out  8  register address
- bus_wdata  out  8  write data
- bus_rdata  in  8  combinational read data from slave
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - all outputs 0 except req_ready=1;
  - state IDLE, counters 0.
  - Reset mid-job aborts immediately: bus strobes drop asynchronously and no res_valid is issued.
- Bus rules:
  - All bus outputs registered; one access per cycle; cs=1 during each access.
  - rd and wr never both 1.
  - Write commits at the clk edge ending the access cycle.
  - Read data sampled from bus_rdata at the edge ending the RD cycle.
  - Idle cycles: cs=rd=wr=0, addr=wdata=0.
- Job accept: req_valid && req_ready at an edge captures all req_* fields; the FSM leaves IDLE.
- FSM sequence, one cycle each unless noted:
  - WR_MODE: addr 0x01, wdata = {4'b0, req_init, req_dt_mode, req_reg_mode, 1'b0}. Mode is set first so the slave does not ignore a dT write.
  - WR_T: 0x02 ← req_T.
  - WR_DT: 0x03 ← req_dT, only if req_dt_mode=0; skipped otherwise.
  - WR_START: 0x01 ← {4'b0, 1'b0, dt_mode, reg_mode, 1'b1}. At least one non-CTRL access separates the two CTRL writes, which re-arms the slave's edge detectors.
  - GAP: POLL_GAP idle cycles.
  - RD_STAT: 0x00. If rdata[1]=1 (valid) and rdata[0]=0 (busy), go to RD_G. Else increment poll_cnt: if poll_cnt reaches MAX_POLLS go to DONE with timeout, else go to GAP.
  - RD_G: read 0x04, capture into res_G.
  - RD_DT: read 0x03, capture into res_dT. Returns the estimator monitor when dt_mode=1.
  - DONE: res_valid=1 for one cycle; res_timeout=1 if timed out. On timeout, res_G=res_dT=0 and no further bus access. Return to IDLE; req_ready=1 the next cycle.
- Core contract: the core clears valid on start_pulse, so stale valid is never observed after the GAP.
- Latency, no timeout, k = number of polls:
  - external dT: 4 + k·(POLL_GAP+1) + 3 cycles from accept to res_valid;
  - internal dT: one cycle less.
- res_G, res_dT and res_timeout hold their values until the next DONE.
- req_valid while busy is ignored; the request is not queued.

Decomposition:
- Package fuzzy_mmio_pkg holds:
  - address constants: ADDR_STATUS=0x00, ADDR_CTRL=0x01, ADDR_T=0x02, ADDR_DT=0x03, ADDR_G=0x04;
  - CTRL bit indices: START=0, REG_MODE=1, DT_MODE=2, INIT=3;
  - STATUS bit indices: BUSY=0, VALID=1;
  - host FSM state enum.
- No sub-module; GAP counter and poll counter are inline.

Test Plan:
- Job T=0x40, dT=0x10, dt_mode=0, reg_mode=1, init=0; slave model ready after 2 polls, G=0x37 → bus writes in order: 0x01←0x02, 0x02←0x40, 0x03←0x10, 0x01←0x03; exactly 2 STATUS reads; res_valid once, res_G=0x37, res_dT=0x10, res_timeout=0.
- dt_mode=1, dT monitor=0x22 → no write to 0x03; WR_START wdata=0x07; res_dT=0x22; latency one cycle shorter than the external-dT case.
- init=1 → first CTRL write wdata[3]=1 and START write wdata[3]=0; slave INIT and START each pulse exactly once.
- Slave never ready, MAX_POLLS=3 → exactly 3 STATUS reads, no read of 0x04, res_valid with res_timeout=1 and res_G=0.
- rst_n asserted during GAP → bus_cs/rd/wr drop to 0 without waiting for clk; req_ready=1; no res_valid; a new job after release completes normally.
- req_valid held high through a job → second job accepted only on the cycle after DONE; no bus cycle has rd&&wr.
